// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: EX-stage handshake between the pipeline and the MDU/HI-LO sequencer.
//   master: EX side, drives the instruction, operands and flush; observes stall and HI/LO control.
//   slave : sequencer side, drives stall, HI/LO control, write data, result and status pulses.
interface mdu_hilo_if #(
    parameter int unsigned DW = 32
);
    logic              op_valid;
    logic [2:0]        op;
    logic [DW-1:0]     rs_val;
    logic [DW-1:0]     rt_val;
    logic              flush;
    logic              stall_o;
    logic              hilo_en;
    logic              hilo_write;
    logic              hilo_src;
    logic              hilo_hi_sel;
    logic [DW-1:0]     hilo_wdata;
    logic [2*DW-1:0]   mdu_result;
    logic              mf_valid;
    logic              div_zero;

    modport master (
        output op_valid, op, rs_val, rt_val, flush,
        input  stall_o, hilo_en, hilo_write, hilo_src, hilo_hi_sel,
               hilo_wdata, mdu_result, mf_valid, div_zero
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, flush,
        output stall_o, hilo_en, hilo_write, hilo_src, hilo_hi_sel,
               hilo_wdata, mdu_result, mf_valid, div_zero
    );
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: multiply/divide sequencer and HI/LO control for the EX stage.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : op_valid/op/rs_val/rt_val/flush in; stall_o, hilo_* controls,
//                   mdu_result {HI,LO}, mf_valid, div_zero out.
// Multiply is shift-add and divide is restoring, one bit per cycle over DW cycles,
// followed by a FIX cycle that sign-corrects and writes HI/LO.
module mdu_hilo_ctrl #(
    parameter int unsigned   DW     = 32,
    parameter logic [DW-1:0] DIV0_Q = {DW{1'b1}}
) (
    input  logic        clk,
    input  logic        rst,
    mdu_hilo_if.slave   bus
);
    localparam int unsigned CW = $clog2(DW);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        READ = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [DW-1:0]   opnd;      // |multiplicand| or |divisor|
    logic [DW-1:0]   rs_orig;   // original rs for the divide-by-zero HI value
    logic            is_div;
    logic            sign_q;
    logic            sign_r;
    logic [2*DW-1:0] res_hold;

    logic            accept;
    logic            acc_md;
    logic            acc_mt;
    logic            acc_mf;
    logic            signed_op;
    logic            rs_neg;
    logic            rt_neg;
    logic [DW-1:0]   rs_abs;
    logic [DW-1:0]   rt_abs;
    logic [DW:0]     mul_add;
    logic [DW:0]     mul_sum;
    logic [DW+1:0]   div_diff;
    logic [2*DW-1:0] acc_next;
    logic            div0;
    logic [DW-1:0]   quot_fix;
    logic [DW-1:0]   rem_fix;
    logic [2*DW-1:0] fix_res;

    // Instruction decode; rst gating keeps outputs at zero while reset is held.
    always_comb begin
        accept    = (state == IDLE) && bus.op_valid && !bus.flush && !rst;
        acc_md    = accept && !bus.op[2];
        acc_mt    = accept && bus.op[2] && !bus.op[1];
        acc_mf    = accept && bus.op[2] && bus.op[1];
        signed_op = !bus.op[0];
        rs_neg    = signed_op && bus.rs_val[DW-1];
        rt_neg    = signed_op && bus.rt_val[DW-1];
        rs_abs    = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_abs    = rt_neg ? -bus.rt_val : bus.rt_val;
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_add  = acc[0] ? {1'b0, opnd} : '0;
        mul_sum  = {1'b0, acc[2*DW-1:DW]} + mul_add;
        div_diff = {1'b0, acc[2*DW-1:DW], acc[DW-1]} - {2'b00, opnd};
        if (!is_div) begin
            acc_next = {mul_sum, acc[DW-1:1]};
        end else if (!div_diff[DW+1]) begin
            acc_next = {div_diff[DW-1:0], acc[DW-2:0], 1'b1};
        end else begin
            acc_next = {acc[2*DW-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero substitution for the FIX cycle.
    always_comb begin
        div0     = is_div && (opnd == '0);
        quot_fix = sign_q ? -acc[DW-1:0] : acc[DW-1:0];
        rem_fix  = sign_r ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
        if (!is_div) begin
            fix_res = sign_q ? -acc : acc;
        end else if (div0) begin
            fix_res = {rs_orig, DIV0_Q};
        end else begin
            fix_res = {rem_fix, quot_fix};
        end
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            rs_orig  <= '0;
            is_div   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            res_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_md) begin
                        is_div  <= bus.op[1];
                        rs_orig <= bus.rs_val;
                        sign_q  <= rs_neg ^ rt_neg;
                        sign_r  <= bus.op[1] && rs_neg;
                        cnt     <= '0;
                        if (bus.op[1]) begin
                            acc  <= {{DW{1'b0}}, rs_abs};
                            opnd <= rt_abs;
                        end else begin
                            acc  <= {{DW{1'b0}}, rt_abs};
                            opnd <= rs_abs;
                        end
                        state <= CALC;
                    end else if (acc_mf) begin
                        state <= READ;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (cnt == CW'(DW - 1)) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        res_hold <= fix_res;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (bus.flush) begin
                state <= IDLE;
            end
        end
    end

    // HI/LO control and pipeline stall, decoded from state and current inputs.
    always_comb begin
        bus.stall_o     = 1'b0;
        bus.hilo_en     = 1'b0;
        bus.hilo_write  = 1'b0;
        bus.hilo_src    = 1'b0;
        bus.hilo_hi_sel = 1'b0;
        bus.hilo_wdata  = '0;
        bus.mdu_result  = res_hold;
        bus.mf_valid    = 1'b0;
        bus.div_zero    = 1'b0;
        case (state)
            IDLE: begin
                if (acc_md) begin
                    bus.stall_o = 1'b1;
                end else if (acc_mt) begin
                    bus.hilo_en     = 1'b1;
                    bus.hilo_write  = 1'b1;
                    bus.hilo_src    = 1'b1;
                    bus.hilo_hi_sel = (bus.op == OP_MTHI);
                    bus.hilo_wdata  = bus.rs_val;
                end else if (acc_mf) begin
                    bus.hilo_en     = 1'b1;
                    bus.hilo_hi_sel = (bus.op == OP_MFHI);
                    bus.stall_o     = 1'b1;
                end
            end
            CALC: begin
                bus.stall_o = !bus.flush;
            end
            FIX: begin
                bus.mdu_result = fix_res;
                bus.hilo_en    = 1'b1;
                bus.hilo_write = !bus.flush;
                bus.div_zero   = div0 && !bus.flush;
            end
            READ: begin
                bus.mf_valid = !bus.flush;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb_mdu_hilo_ctrl: directed bench for mdu_hilo_ctrl with a small HI/LO register model.
module tb_mdu_hilo_ctrl;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] hi_reg;
    logic [DW-1:0] lo_reg;
    logic [DW-1:0] rdata;

    mdu_hilo_if #(.DW(DW)) bus ();

    mdu_hilo_ctrl #(
        .DW     (DW),
        .DIV0_Q (32'hFFFF_FFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External HI/LO register pair steered by the controller outputs.
    always @(posedge clk) begin
        if (bus.hilo_en && bus.hilo_write) begin
            if (bus.hilo_src) begin
                if (bus.hilo_hi_sel) hi_reg <= bus.hilo_wdata;
                else                 lo_reg <= bus.hilo_wdata;
            end else begin
                {hi_reg, lo_reg} <= bus.mdu_result;
            end
        end
        if (bus.hilo_en && !bus.hilo_write) begin
            rdata <= bus.hilo_hi_sel ? hi_reg : lo_reg;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = v;
        bus.op       = o;
        bus.rs_val   = a;
        bus.rt_val   = b;
    endtask

    // Issue a multiply/divide, hold it under stall, check latency and the FIX-cycle write.
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input logic exp_dz);
        int   stall_cnt;
        logic early_wr;
        tick();
        drive(1'b1, o, a, b);
        #1;
        stall_cnt = int'(bus.stall_o);
        early_wr  = bus.hilo_write;
        for (int k = 0; k < 32; k++) begin
            tick();
            #1;
            stall_cnt += int'(bus.stall_o);
            early_wr  |= bus.hilo_write | bus.div_zero;
        end
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd33);
        check({tag, "_early_write"}, 64'(early_wr), 64'd0);
        tick();
        #1;
        check({tag, "_fix_ctrl"}, {60'd0, bus.stall_o, bus.hilo_en, bus.hilo_write, bus.hilo_src},
              64'b0110);
        check({tag, "_result"}, bus.mdu_result, exp);
        check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check({tag, "_after"}, {61'd0, bus.stall_o, bus.hilo_write, bus.div_zero}, 64'd0);
        check({tag, "_hold"}, bus.mdu_result, exp);
        check({tag, "_hilo_regs"}, {hi_reg, lo_reg}, exp);
    endtask

    initial begin
        logic saw_wr;
        n_checks = 0;
        n_fail   = 0;
        rst       = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) tick();
        check("reset_outputs", {bus.mdu_result[59:0], bus.stall_o, bus.hilo_en, bus.mf_valid, bus.div_zero},
              64'd0);
        rst = 1'b0;
        tick();

        run_md("mult",  3'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_md("multu", 3'd1, 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, 1'b0);
        run_md("divu",  3'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
        run_md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        run_md("divu_zero", 3'd3, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1'b1);

        // MTHI then MFHI back-to-back.
        tick();
        drive(1'b1, 3'd4, 32'hCAFE_BABE, 32'd0);
        #1;
        check("mthi_ctrl", {59'd0, bus.stall_o, bus.hilo_en, bus.hilo_write, bus.hilo_src, bus.hilo_hi_sel},
              64'b01111);
        check("mthi_wdata", 64'(bus.hilo_wdata), 64'h0000_0000_CAFE_BABE);
        tick();
        drive(1'b1, 3'd6, 32'd0, 32'd0);
        #1;
        check("mfhi_req", {59'd0, bus.stall_o, bus.hilo_en, bus.hilo_write, bus.hilo_hi_sel, bus.mf_valid},
              64'b11010);
        tick();
        #1;
        check("mfhi_read", {62'd0, bus.stall_o, bus.mf_valid}, 64'b01);
        check("mfhi_data", 64'(rdata), 64'h0000_0000_CAFE_BABE);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check("mfhi_done", {62'd0, bus.stall_o, bus.mf_valid}, 64'd0);

        // MTLO then MFLO.
        drive(1'b1, 3'd5, 32'h1111_2222, 32'd0);
        #1;
        check("mtlo_ctrl", {60'd0, bus.hilo_write, bus.hilo_src, bus.hilo_hi_sel, bus.stall_o}, 64'b1100);
        tick();
        drive(1'b1, 3'd7, 32'd0, 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check("mflo_data", {31'd0, bus.mf_valid, rdata}, {31'd0, 1'b1, 32'h1111_2222});
        check("mthi_kept", 64'(hi_reg), 64'h0000_0000_CAFE_BABE);

        // Flush a MULT at counter 10, then a DIVU runs normally.
        tick();
        drive(1'b1, 3'd0, 32'd7, 32'd9);
        repeat (11) tick();
        bus.flush = 1'b1;
        #1;
        check("flush_cycle", {62'd0, bus.stall_o, bus.hilo_write}, 64'd0);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check("flush_idle", {62'd0, bus.stall_o, bus.hilo_write}, 64'd0);
        run_md("divu_post_flush", 3'd3, 32'hFFFF_FFFF, 32'h10, 64'h0000_000F_0FFF_FFFF, 1'b0);

        // Flush landing on the FIX cycle suppresses the write.
        tick();
        drive(1'b1, 3'd1, 32'd2, 32'd3);
        repeat (33) tick();
        bus.flush = 1'b1;
        #1;
        check("flush_fix", {61'd0, bus.hilo_write, bus.div_zero, bus.stall_o}, 64'd0);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check("flush_fix_regs", {hi_reg, lo_reg}, 64'h0000_000F_0FFF_FFFF);

        // Asynchronous reset mid-CALC.
        tick();
        drive(1'b1, 3'd0, 32'd3, 32'd4);
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {bus.mdu_result[59:0], bus.stall_o, bus.hilo_en, bus.hilo_write, bus.mf_valid},
              64'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        saw_wr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            saw_wr |= bus.hilo_write | bus.stall_o;
        end
        check("rst_no_write", 64'(saw_wr), 64'd0);
        check("rst_regs_kept", {hi_reg, lo_reg}, 64'h0000_000F_0FFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
